user_port_arbiter: RTL
======================

# user_port_arbiter

Shares the single user RAM port B (13-bit word address, 32-bit data, synchronous read) of the data cache between two requesters: the host loader/debugger (requester 0) and the EDC scrub sequencer (requester 1). It runs round-robin arbitration and supports a lock, so a requester can keep the port for a read-modify-write. An idle-lock timeout prevents deadlock, and a hold input freezes grants during EDC error injection. Its memory-side outputs drive user_addr/user_we/user_din of the MEM stage. user_dout returns through it, tagged to the issuing requester.

## Interface
- RD_LAT, 1: cycles from address presented on mem_addr to valid mem_dout (1..4).
- LOCK_TO, 15: consecutive idle owner cycles before a lock is forcibly released (1..255).
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- hold  in  1  suppresses all grants (driven by error_dwe | error_pwe).
- reqN_req  in  1  request valid, N = 0,1.
- reqN_we  in  1  1 = write, 0 = read.
- reqN_lock  in  1  keep ownership after this access.
- reqN_addr  in  13  word address.
- reqN_din  in  32  write data.
- reqN_gnt  out  1  combinational; request accepted this cycle.
- reqN_rvalid  out  1  read data valid for requester N.
- reqN_rdata  out  32  read data (mem_dout registered-through; don't-care when rvalid = 0).
- mem_addr  out  13  to user_addr.
- mem_we  out  1  to user_we.
- mem_din  out  32  to user_din.
- mem_dout  in  32  from user_dout.
- lock_owner  out  2  00 none, 01 req0, 10 req1 (status/debug).

## Operation
- FSM states: FREE, LOCK0, LOCK1.
- FREE:
  - hold = 1 → no grant.
  - Exactly one requester asserts req → it is granted.
  - Both assert req → grant the one not granted last; last_gnt resets to 1, so req0 wins the first tie.
- A granted access with lock = 1 moves the FSM to LOCKn (n = granted requester). With lock = 0, the FSM stays in / returns to FREE.
- LOCKn:
  - Only requester n can be granted. The other requester's gnt stays 0 even if it is requesting.
  - A granted access from n with lock = 0 → FREE after that cycle.
  - The idle counter increments on each cycle with no reqn_req and hold = 0. It is cleared on any grant.
  - Counter reaching LOCK_TO → FREE. This release takes effect from the next cycle.
- hold = 1: gnt = 0 for both requesters. FSM state, last_gnt and the idle counter are frozen. In-flight reads still complete.
- Grant cycle T: mem_addr/mem_we/mem_din are registered from the granted request and presented at T+1.
- Non-grant cycles: mem_we = 0; mem_addr and mem_din keep their last value.
- Read tag pipeline:
  - Each granted read pushes {valid, owner} into an RD_LAT+1 deep shift register.
  - At the tail: reqN_rvalid = valid & (owner == N), and reqN_rdata = mem_dout.
  - Writes push valid = 0.
- Back-to-back grants, one per cycle, are allowed. There is no limit on reads in flight.

## Timing
- Grant: 0 cycles, combinational from reqN_req, hold, state and last_gnt.
- Write: reaches memory at T+1.
- Read: rvalid at T+1+RD_LAT (T+2 with default RD_LAT).
- Reset values:
  - Outputs: gnt = 0, rvalid = 0, mem_we = 0, mem_addr = 0, mem_din = 0, lock_owner = 00.
  - Internal: state FREE, idle counter 0, all tag valids 0, last_gnt = 1.
- Reset mid-read: the tag pipeline is cleared and no rvalid is produced for the dropped reads.
- Timeout and an owner request in the same cycle: the request is granted and the counter is cleared; the grant wins.
- Release cycle (lock = 0 grant): the other requester can be granted on the next cycle, not in the release cycle.

## Structure
- Shared package user_arb_pkg:
  - state enum (FREE/LOCK0/LOCK1)
  - requester ID constants REQ_HOST = 0, REQ_SCRUB = 1
  - UADDR_W = 13, UDATA_W = 32
- Sub-module user_rd_tag_pipe: parameterised by RD_LAT. Holds the {valid, owner} shift register and produces the rvalid demux.

## Test plan
- Single read, req0 at 0x0A5, mem returns 0xDEADBEEF → req0_gnt at T, mem_addr = 0x0A5, mem_we = 0 at T+1, req0_rvalid with 0xDEADBEEF at T+2, req1_rvalid = 0 throughout.
- Both requesting reads for 4 cycles → grants alternate 0,1,0,1 and rvalids return in the same order, 2 cycles later.
- req1 locked read of 0x100, then write of 0x100 with lock = 0, while req0 requests continuously → req0_gnt = 0 until the cycle after req1's write grant. lock_owner = 10 during that window.
- req1 locks, then idles; LOCK_TO = 15 → lock_owner returns to 00 after 15 idle cycles, and a pending req0 is granted on the following cycle.
- hold = 1 for 3 cycles, with a read granted the cycle before → no gnt during hold, but the earlier read's rvalid still appears. The idle counter does not advance.
- rst asserted one cycle after a read grant → no rvalid follows, and all outputs are at their reset values on the next cycle.

Source files
------------

// File: rtl/user_arb_pkg.sv
// Shared types and constants for the user RAM port B arbiter slice.
// Pure declarations: no logic, no latency, no flow control.
package user_arb_pkg;

  localparam int UADDR_W = 13;
  localparam int UDATA_W = 32;

  localparam logic REQ_HOST  = 1'b0;
  localparam logic REQ_SCRUB = 1'b1;

  // Encoding matches the lock_owner status field.
  typedef enum logic [1:0] {
    FREE  = 2'b00,
    LOCK0 = 2'b01,
    LOCK1 = 2'b10
  } arb_state_e;

endpackage

// File: rtl/user_rd_tag_pipe.sv
// Tracks which requester issued each in-flight read and steers mem_dout back to it.
// Tag surfaces RD_LAT+1 cycles after the grant; never stalls, accepts one push per cycle.
module user_rd_tag_pipe
  import user_arb_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push_vld,
  input  logic               push_owner,
  input  logic [UDATA_W-1:0] mem_dout,
  output logic               req0_rvalid,
  output logic [UDATA_W-1:0] req0_rdata,
  output logic               req1_rvalid,
  output logic [UDATA_W-1:0] req1_rdata
);

  localparam int DEPTH = RD_LAT + 1;

  logic [DEPTH-1:0] vld_q, vld_d;
  logic [DEPTH-1:0] own_q, own_d;

  always_comb begin
    vld_d = {vld_q[DEPTH-2:0], push_vld};
    own_d = {own_q[DEPTH-2:0], push_owner};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      own_q <= '0;
    end else begin
      vld_q <= vld_d;
      own_q <= own_d;
    end
  end

  always_comb begin
    req0_rvalid = vld_q[DEPTH-1] & (own_q[DEPTH-1] == REQ_HOST);
    req1_rvalid = vld_q[DEPTH-1] & (own_q[DEPTH-1] == REQ_SCRUB);
    req0_rdata  = mem_dout;
    req1_rdata  = mem_dout;
  end

endmodule

// File: rtl/user_port_arbiter.sv
// Round-robin arbiter with lock/idle-timeout sharing user RAM port B between host and scrubber.
// Grant is combinational, access presented one cycle later; losers and hold simply see gnt = 0.
module user_port_arbiter
  import user_arb_pkg::*;
#(
  parameter int RD_LAT  = 1,
  parameter int LOCK_TO = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hold,
  input  logic               req0_req,
  input  logic               req0_we,
  input  logic               req0_lock,
  input  logic [UADDR_W-1:0] req0_addr,
  input  logic [UDATA_W-1:0] req0_din,
  output logic               req0_gnt,
  output logic               req0_rvalid,
  output logic [UDATA_W-1:0] req0_rdata,
  input  logic               req1_req,
  input  logic               req1_we,
  input  logic               req1_lock,
  input  logic [UADDR_W-1:0] req1_addr,
  input  logic [UDATA_W-1:0] req1_din,
  output logic               req1_gnt,
  output logic               req1_rvalid,
  output logic [UDATA_W-1:0] req1_rdata,
  output logic [UADDR_W-1:0] mem_addr,
  output logic               mem_we,
  output logic [UDATA_W-1:0] mem_din,
  input  logic [UDATA_W-1:0] mem_dout,
  output logic [1:0]         lock_owner
);

  localparam logic [7:0] IDLE_LAST = 8'(LOCK_TO - 1);

  arb_state_e         state_q, state_d;
  logic               last_gnt_q, last_gnt_d;
  logic [7:0]         idle_q, idle_d;
  logic [UADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic               mem_we_q, mem_we_d;
  logic [UDATA_W-1:0] mem_din_q, mem_din_d;

  logic               gnt_any;
  logic               gnt_id;
  logic               sel_we;
  logic               sel_lock;
  logic [UADDR_W-1:0] sel_addr;
  logic [UDATA_W-1:0] sel_din;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FREE;
      last_gnt_q <= REQ_SCRUB;
      idle_q     <= '0;
      mem_addr_q <= '0;
      mem_we_q   <= 1'b0;
      mem_din_q  <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      idle_q     <= idle_d;
      mem_addr_q <= mem_addr_d;
      mem_we_q   <= mem_we_d;
      mem_din_q  <= mem_din_d;
    end
  end

  // Grants and status depend only on current state and live requests.
  always_comb begin
    req0_gnt   = 1'b0;
    req1_gnt   = 1'b0;
    lock_owner = 2'b00;
    case (state_q)
      FREE: begin
        if (!rst && !hold) begin
          if (req0_req && (!req1_req || last_gnt_q == REQ_SCRUB)) req0_gnt = 1'b1;
          else if (req1_req)                                      req1_gnt = 1'b1;
        end
      end
      LOCK0: begin
        req0_gnt   = !rst && !hold && req0_req;
        lock_owner = 2'b01;
      end
      LOCK1: begin
        req1_gnt   = !rst && !hold && req1_req;
        lock_owner = 2'b10;
      end
      default: ;
    endcase
  end

  always_comb begin
    gnt_any  = req0_gnt | req1_gnt;
    gnt_id   = req1_gnt;
    sel_we   = gnt_id ? req1_we   : req0_we;
    sel_lock = gnt_id ? req1_lock : req0_lock;
    sel_addr = gnt_id ? req1_addr : req0_addr;
    sel_din  = gnt_id ? req1_din  : req0_din;
  end

  // A grant always beats the timeout, so the counter only runs while the owner is silent.
  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    idle_d     = idle_q;
    if (gnt_any) begin
      last_gnt_d = gnt_id;
      idle_d     = '0;
      state_d    = sel_lock ? (gnt_id ? LOCK1 : LOCK0) : FREE;
    end else if (!hold && state_q != FREE) begin
      if (idle_q == IDLE_LAST) begin
        idle_d  = '0;
        state_d = FREE;
      end else begin
        idle_d = idle_q + 8'd1;
      end
    end
  end

  always_comb begin
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    mem_we_d   = 1'b0;
    if (gnt_any) begin
      mem_addr_d = sel_addr;
      mem_din_d  = sel_din;
      mem_we_d   = sel_we;
    end
  end

  assign mem_addr = mem_addr_q;
  assign mem_we   = mem_we_q;
  assign mem_din  = mem_din_q;

  user_rd_tag_pipe #(.RD_LAT(RD_LAT)) u_tag_pipe (
    .clk         (clk),
    .rst         (rst),
    .push_vld    (gnt_any & ~sel_we),
    .push_owner  (gnt_id),
    .mem_dout    (mem_dout),
    .req0_rvalid (req0_rvalid),
    .req0_rdata  (req0_rdata),
    .req1_rvalid (req1_rvalid),
    .req1_rdata  (req1_rdata)
  );

endmodule
